// File: rtl/irq_pending_encoder.sv
// irq_pending_encoder: latches 32 request lines into a pending register and
// hands out one pending index at a time as a 5-bit code over a valid/ready
// handshake. Selection is round-robin from a rotating pointer or fixed
// priority (lowest index wins). VALID and IDX come straight from registers.
module irq_pending_encoder #(
    parameter int ROUND_ROBIN = 1,
    parameter int RESET_PTR   = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] REQ,
    input  logic [31:0] MASK,
    input  logic        READY,
    output logic        VALID,
    output logic [4:0]  IDX,
    output logic [31:0] PEND
);

    logic [4:0]  ptr;
    logic        acc;
    logic [31:0] clr;
    logic [31:0] cand;
    logic [63:0] cand_rot;
    logic        sel_any;
    logic [4:0]  sel_idx;

    // Index of the lowest set bit; returns 0 for an all-zero vector (callers
    // gate the result with sel_any).
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) res = 5'(i);
        end
        return res;
    endfunction

    // Accept decode, candidate vector and winner search.
    always_comb begin
        acc      = VALID & READY;
        clr      = acc ? (32'd1 << IDX) : 32'd0;
        cand     = PEND & MASK & ~clr;
        sel_any  = |cand;
        // Rotating right by ptr puts bit ptr at position 0, so the lowest set
        // bit of the rotated vector is the first hit scanning upward from ptr.
        cand_rot = {cand, cand} >> ptr;
        if (ROUND_ROBIN != 0) begin
            sel_idx = ptr + lowest_set(cand_rot[31:0]);
        end else begin
            sel_idx = lowest_set(cand);
        end
    end

    // Pending register: a new request wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PEND <= 32'd0;
        end else begin
            PEND <= (PEND & ~clr) | REQ;
        end
    end

    // Output stage: reloads only when empty or when the held index is taken,
    // so a stalled index never changes under the consumer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VALID <= 1'b0;
            IDX   <= 5'd0;
        end else if (!VALID || acc) begin
            VALID <= sel_any;
            if (sel_any) begin
                IDX <= sel_idx;
            end
        end
    end

    // Round-robin pointer: next search starts just after the accepted index.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= 5'(RESET_PTR);
        end else if (acc) begin
            ptr <= IDX + 5'd1;
        end
    end

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Testbench for irq_pending_encoder: one round-robin instance (reset pointer
// 30) and one fixed-priority instance share the same stimulus; both are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_irq_pending_encoder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] REQ;
    logic [31:0] MASK;
    logic        READY;

    logic        valid_rr, valid_fp;
    logic [4:0]  idx_rr, idx_fp;
    logic [31:0] pend_rr, pend_fp;

    int checks = 0;
    int errors = 0;

    // Model state: unit 0 = round-robin (reset pointer 30), unit 1 = fixed.
    logic [31:0] m_pend  [2];
    logic        m_valid [2];
    logic [4:0]  m_idx   [2];
    int          m_ptr   [2];

    irq_pending_encoder #(.ROUND_ROBIN(1), .RESET_PTR(30)) u_rr (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .MASK(MASK), .VALID(valid_rr),
        .IDX(idx_rr), .READY(READY), .PEND(pend_rr)
    );

    irq_pending_encoder #(.ROUND_ROBIN(0), .RESET_PTR(0)) u_fp (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .MASK(MASK), .VALID(valid_fp),
        .IDX(idx_fp), .READY(READY), .PEND(pend_fp)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next state of one unit from the rules: accept clears the served bit,
    // requests set bits, a new winner is chosen only when empty or accepted.
    task automatic model_step(input int u);
        logic        acc;
        logic [31:0] clr;
        logic [31:0] cand;
        logic        found;
        int          sel;
        int          j;
        if (RESET) begin
            m_pend[u]  = 32'd0;
            m_valid[u] = 1'b0;
            m_idx[u]   = 5'd0;
            m_ptr[u]   = (u == 0) ? 30 : 0;
            return;
        end
        acc  = m_valid[u] && READY;
        clr  = 32'd0;
        if (acc) clr[m_idx[u]] = 1'b1;
        cand = m_pend[u] & MASK & ~clr;
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < 32; k++) begin
            j = (u == 0) ? (m_ptr[u] + k) % 32 : k;
            if (!found && cand[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        if (acc) m_ptr[u] = (int'(m_idx[u]) + 1) % 32;
        m_pend[u] = (m_pend[u] & ~clr) | REQ;
        if (!m_valid[u] || acc) begin
            m_valid[u] = found;
            if (found) m_idx[u] = 5'(sel);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        #1;
        check("rr_valid", 32'(valid_rr), 32'(m_valid[0]));
        check("rr_pend", pend_rr, m_pend[0]);
        check("fp_valid", 32'(valid_fp), 32'(m_valid[1]));
        check("fp_pend", pend_fp, m_pend[1]);
        check("rr_ptr", 32'(u_rr.ptr), 32'(m_ptr[0]));
        if (m_valid[0]) check("rr_idx", 32'(idx_rr), 32'(m_idx[0]));
        if (m_valid[1]) check("fp_idx", 32'(idx_fp), 32'(m_idx[1]));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ   = 32'd0;
        MASK  = '1;
        READY = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        m_pend  = '{32'd0, 32'd0};
        m_valid = '{1'b0, 1'b0};
        m_idx   = '{5'd0, 5'd0};
        m_ptr   = '{30, 0};

        // Reset with all requests high, then release.
        RESET = 1'b1; REQ = '1; MASK = '1; READY = 1'b0;
        tick();
        tick();
        check("rst_pend", pend_fp, 32'd0);
        check("rst_valid", 32'(valid_fp), 32'd0);
        check("rst_idx", 32'(idx_fp), 32'd0);
        check("rst_idx_rr", 32'(idx_rr), 32'd0);
        RESET = 1'b0;
        tick();
        check("lat_valid_low", 32'(valid_fp), 32'd0);
        REQ = 32'd0;
        tick();
        check("lat_valid", 32'(valid_fp), 32'd1);
        check("lat_idx_fp", 32'(idx_fp), 32'd0);
        check("lat_idx_rr", 32'(idx_rr), 32'd30);

        // Round-robin wrap from pointer 30.
        do_reset();
        REQ = 32'h8000_0003; READY = 1'b1;
        tick();
        REQ = 32'd0;
        tick();
        check("wrap_idx0", 32'(idx_rr), 32'd31);
        tick();
        check("wrap_idx1", 32'(idx_rr), 32'd0);
        tick();
        check("wrap_idx2", 32'(idx_rr), 32'd1);
        check("wrap_valid2", 32'(valid_rr), 32'd1);
        tick();
        check("wrap_done_valid", 32'(valid_rr), 32'd0);
        check("wrap_done_pend", pend_rr, 32'd0);
        check("wrap_done_ptr", 32'(u_rr.ptr), 32'd2);

        // Fixed priority and hold under stall.
        do_reset();
        REQ = 32'd1 << 9;
        tick();
        REQ = 32'd0;
        tick();
        check("hold_idx9", 32'(idx_fp), 32'd9);
        REQ = 32'd1 << 2;
        tick();
        REQ = 32'd0;
        check("hold_still9", 32'(idx_fp), 32'd9);
        tick();
        check("hold_still9b", 32'(idx_fp), 32'd9);
        check("hold_valid", 32'(valid_fp), 32'd1);
        READY = 1'b1;
        tick();
        check("hold_next2", 32'(idx_fp), 32'd2);
        tick();
        check("hold_empty", 32'(valid_fp), 32'd0);

        // Set wins over the same-cycle clear.
        do_reset();
        REQ = 32'd1 << 5;
        tick();
        REQ = 32'd0;
        tick();
        check("sw_idx5", 32'(idx_fp), 32'd5);
        REQ = 32'd1 << 5; READY = 1'b1;
        tick();
        REQ = 32'd0;
        check("sw_pend5", pend_fp, 32'h0000_0020);
        tick();
        check("sw_again_valid", 32'(valid_fp), 32'd1);
        check("sw_again_idx", 32'(idx_fp), 32'd5);
        tick();
        check("sw_done_pend", pend_fp, 32'd0);

        // Masked bit stays pending until unmasked.
        do_reset();
        READY = 1'b1; MASK = 32'hFFFF_FFEF; REQ = 32'h0000_0011;
        tick();
        REQ = 32'd0;
        tick();
        check("mask_idx0", 32'(idx_fp), 32'd0);
        check("mask_idx0_rr", 32'(idx_rr), 32'd0);
        tick();
        check("mask_valid_low", 32'(valid_fp), 32'd0);
        check("mask_pend", pend_fp, 32'h0000_0010);
        tick();
        MASK = '1;
        tick();
        check("mask_idx4", 32'(idx_fp), 32'd4);
        check("mask_valid4", 32'(valid_fp), 32'd1);
        tick();
        check("mask_done", pend_fp, 32'd0);

        // Reset while an index is held.
        do_reset();
        REQ = 32'd1 << 7;
        tick();
        REQ = 32'd0;
        tick();
        check("mid_idx7", 32'(idx_rr), 32'd7);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_valid", 32'(valid_rr), 32'd0);
        check("mid_pend", pend_rr, 32'd0);
        check("mid_ptr", 32'(u_rr.ptr), 32'd30);
        tick();
        check("mid_stay_idle", 32'(valid_rr), 32'd0);

        // All 32 pending, served back to back.
        do_reset();
        READY = 1'b1; REQ = '1;
        tick();
        REQ = 32'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("b2b_rr_idx", 32'(idx_rr), 32'((30 + i) % 32));
            check("b2b_fp_idx", 32'(idx_fp), 32'(i));
        end
        tick();
        check("b2b_done_valid", 32'(valid_rr), 32'd0);
        check("b2b_done_pend", pend_rr, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            RESET = ($urandom_range(0, 79) == 0);
            REQ   = (n % 50 < 40) ? ($urandom & $urandom & $urandom) : 32'd0;
            MASK  = $urandom | $urandom | $urandom;
            READY = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
